// File: rtl/register_swap_sequencer.sv
// register_swap_sequencer: issues one swap command per clock to apply a whole-file permutation
module register_swap_sequencer #(
   parameter int N_REGS = 8,
   parameter int IDX_W  = $clog2(N_REGS)
) (
   input  logic             clk,
   input  logic             init,
   input  logic             start,
   input  logic [1:0]       mode,
   output logic             busy,
   output logic             done,
   output logic             swapxy,
   output logic [IDX_W-1:0] x,
   output logic [IDX_W-1:0] y
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
   localparam logic [IDX_W-1:0] TOP       = IDX_W'(N_REGS - 1);
   localparam logic [IDX_W-1:0] LAST_ROT  = IDX_W'(N_REGS - 2);
   localparam logic [IDX_W-1:0] LAST_HALF = IDX_W'(N_REGS / 2 - 1);
   state_t           state, state_n;
   logic [IDX_W-1:0] k, k_n, last;
   logic [1:0]       mode_q, mode_n;
   // state, pair counter and latched mode; reset aborts any sequence in flight
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state  <= IDLE;
         k      <= '0;
         mode_q <= 2'b00;
      end else begin
         state  <= state_n;
         k      <= k_n;
         mode_q <= mode_n;
      end
   end
   // next state and outputs; outputs depend only on flops, never on start/mode directly
   always_comb begin
      state_n = state;
      k_n     = k;
      mode_n  = mode_q;
      busy    = state != IDLE;
      done    = state == DONE;
      swapxy  = state == RUN;
      x       = '0;
      y       = '0;
      last    = mode_q == 2'b01 ? LAST_ROT : LAST_HALF;
      if (state == IDLE && start) begin
         mode_n  = mode;
         k_n     = '0;
         state_n = mode == 2'b11 ? DONE : RUN;
      end
      if (state == RUN) begin
         k_n     = k + ONE;
         state_n = k == last ? DONE : RUN;
         x       = mode_q == 2'b10 ? k << 1 : k;
         y       = mode_q == 2'b00 ? TOP - k : mode_q == 2'b01 ? k + ONE : (k << 1) | ONE;
      end
      if (state == DONE) begin
         state_n = IDLE;
         k_n     = '0;
      end
   end
endmodule

// File: tb/tb_register_swap_sequencer.sv
// tb_register_swap_sequencer: directed checks of the swap sequencer driving a behavioural 8x4 swap file
module tb_register_swap_sequencer;
   typedef int vec_t[8];
   logic       clk = 0, init, start, load;
   logic [1:0] mode;
   logic       busy, done, swapxy;
   logic [2:0] x, y;
   logic [3:0] r[8];
   int         tests = 0, fails = 0;
   vec_t       rev_x = '{0, 1, 2, 3, 0, 0, 0, 0};
   vec_t       rev_y = '{7, 6, 5, 4, 0, 0, 0, 0};
   vec_t       rot_x = '{0, 1, 2, 3, 4, 5, 6, 0};
   vec_t       rot_y = '{1, 2, 3, 4, 5, 6, 7, 0};
   vec_t       pw_x  = '{0, 2, 4, 6, 0, 0, 0, 0};
   vec_t       pw_y  = '{1, 3, 5, 7, 0, 0, 0, 0};
   vec_t       none  = '{0, 0, 0, 0, 0, 0, 0, 0};
   register_swap_sequencer #(.N_REGS(8)) dut (
      .clk(clk), .init(init), .start(start), .mode(mode),
      .busy(busy), .done(done), .swapxy(swapxy), .x(x), .y(y)
   );
   always #5 clk = ~clk;
   // behavioural swap file: identity preload on load, otherwise swap r[x] and r[y] on command
   always @(posedge clk) begin
      if (load) begin
         for (int i = 0; i < 8; i++) r[i] <= 4'(i);
      end else if (swapxy) begin
         r[x] <= r[y];
         r[y] <= r[x];
      end
   end
   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic preload();
      @(negedge clk) load = 1;
      @(negedge clk) load = 0;
   endtask
   task automatic launch(input logic [1:0] m);
      @(negedge clk);
      start = 1;
      mode  = m;
      @(negedge clk);
      start = 0;
   endtask
   task automatic check_pairs(input string tag, input int kk, input vec_t ex, input vec_t ey);
      for (int i = 0; i < kk; i++) begin
         check({tag, "_swapxy"}, swapxy, 1);
         check({tag, "_busy"}, busy, 1);
         check({tag, "_done_early"}, done, 0);
         check($sformatf("%s_x%0d", tag, i), x, ex[i]);
         check($sformatf("%s_y%0d", tag, i), y, ey[i]);
         @(negedge clk);
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_done_swapxy"}, swapxy, 0);
      check({tag, "_done_busy"}, busy, 1);
      check({tag, "_done_x"}, x, 0);
      check({tag, "_done_y"}, y, 0);
      @(negedge clk);
      check({tag, "_idle_busy"}, busy, 0);
      check({tag, "_idle_done"}, done, 0);
      check({tag, "_idle_swapxy"}, swapxy, 0);
   endtask
   task automatic check_file(input string tag, input vec_t e);
      for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", tag, i), r[i], e[i]);
   endtask
   initial begin
      init  = 1;
      start = 0;
      mode  = 2'b00;
      load  = 0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_swapxy", swapxy, 0);
      check("rst_x", x, 0);
      check("rst_y", y, 0);
      repeat (2) @(negedge clk);
      init = 0;
      @(negedge clk);
      #2 init = 1;
      #1;
      check("rst1_busy", busy, 0);
      check("rst1_done", done, 0);
      check("rst1_swapxy", swapxy, 0);
      check("rst1_x", x, 0);
      check("rst1_y", y, 0);
      #1 init = 0;
      preload();
      launch(2'b00);
      check_pairs("rev", 4, rev_x, rev_y);
      check_file("rev_file", '{7, 6, 5, 4, 3, 2, 1, 0});
      preload();
      launch(2'b01);
      check_pairs("rot", 7, rot_x, rot_y);
      check_file("rot_file", '{1, 2, 3, 4, 5, 6, 7, 0});
      preload();
      launch(2'b10);
      check_pairs("pw", 4, pw_x, pw_y);
      check_file("pw_file", '{1, 0, 3, 2, 5, 4, 7, 6});
      launch(2'b11);
      check_pairs("nop", 0, none, none);
      check_file("nop_file", '{1, 0, 3, 2, 5, 4, 7, 6});
      preload();
      launch(2'b00);
      start = 1;
      mode  = 2'b01;
      check_pairs("busy_rev", 4, rev_x, rev_y);
      @(negedge clk);
      start = 0;
      mode  = 2'b10;
      check_pairs("held_rot", 7, rot_x, rot_y);
      check_file("held_file", '{6, 5, 4, 3, 2, 1, 0, 7});
      preload();
      launch(2'b00);
      @(negedge clk);
      @(negedge clk);
      check("abort_pre_swapxy", swapxy, 1);
      check("abort_pre_x", x, 2);
      #1 init = 1;
      #1;
      check("abort_swapxy", swapxy, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_x", x, 0);
      check("abort_y", y, 0);
      check_file("abort_file", '{7, 6, 2, 3, 4, 5, 1, 0});
      #1 init = 0;
      repeat (2) @(negedge clk);
      check("abort_idle_busy", busy, 0);
      launch(2'b00);
      check_pairs("fresh", 4, rev_x, rev_y);
      check_file("fresh_file", '{0, 1, 5, 4, 3, 2, 6, 7});
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
